// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared execution-unit encodings and width helpers
//
// Contents:
//   ex_unit_e  : channel encodings for the dispatch stage
//   ex_width   : bits needed to encode a channel index plus a NOP code
//   cnt_width  : bits needed for an occupancy count of 0..depth

package vx_gpu_pkg;

    typedef enum logic [2:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_CSR = 3'd2,
        EX_FPU = 3'd3,
        EX_GPU = 3'd4
    } ex_unit_e;

    localparam int EX_UNITS = 5;

    // Leaves room for at least one code >= num_ex, which is the NOP encoding.
    function automatic int ex_width(input int num_ex);
        return $clog2(num_ex + 1);
    endfunction

    // One extra bit so that a completely full queue (count == depth) fits.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vx_gen_dispatch_queue.sv
// rtl/vx_gen_dispatch_queue.sv - one dispatch channel: FIFO plus stall counter
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   flush             : clear pointers and count at the next edge
//   push, push_data   : write one entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   stall             : increment the saturating backpressure counter
//   full, count       : queue status from flops only
//   head_data         : oldest entry
//   stalls            : backpressure cycle count

module vx_gen_dispatch_queue
    import vx_gpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATAW  = 256,
    parameter int PERF_W = 16,
    parameter int CNTW   = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATAW-1:0]  push_data,
    input  logic              pop,
    input  logic              stall,
    output logic              full,
    output logic [CNTW-1:0]   count,
    output logic [DATAW-1:0]  head_data,
    output logic [PERF_W-1:0] stalls
);

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [PERF_W-1:0] stalls_q, stalls_d;
    logic [DATAW-1:0]  mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full      = (count_q == CNTW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign stalls    = stalls_q;

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && (count_q != '0) && !flush;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Stall counts survive a flush; only reset clears them.
    always_comb begin
        stalls_d = stalls_q;
        if (stall && (stalls_q != '1)) begin
            stalls_d = stalls_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stalls_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stalls_q <= stalls_d;
        end
    end

    // Payload storage is not reset; an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vx_gen_dispatch.sv
// rtl/vx_gen_dispatch.sv - routes issued requests into per-unit dispatch queues
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid, in_ready    : issue handshake
//   in_ex_type            : target channel; codes >= NUM_EX are NOPs
//   in_data               : request payload
//   flush                 : discard every queued request
//   out_valid, out_ready  : per-channel dispatch handshake
//   out_data              : channel i at [i*DATAW +: DATAW]
//   occupancy             : channel i count at [i*CNTW +: CNTW]
//   perf_stalls           : channel i backpressure cycles at [i*PERF_W +: PERF_W]
//   perf_nops             : consumed NOP count

module vx_gen_dispatch
    import vx_gpu_pkg::*;
#(
    parameter int NUM_EX = 5,
    parameter int DEPTH  = 2,
    parameter int DATAW  = 256,
    parameter int PERF_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ex_width(NUM_EX)-1:0]     in_ex_type,
    input  logic [DATAW-1:0]                in_data,
    input  logic                            flush,
    output logic [NUM_EX-1:0]               out_valid,
    input  logic [NUM_EX-1:0]               out_ready,
    output logic [NUM_EX*DATAW-1:0]         out_data,
    output logic [NUM_EX*cnt_width(DEPTH)-1:0] occupancy,
    output logic [NUM_EX*PERF_W-1:0]        perf_stalls,
    output logic [PERF_W-1:0]               perf_nops
);

    localparam int EXW  = ex_width(NUM_EX);
    localparam int CNTW = cnt_width(DEPTH);

    logic [NUM_EX-1:0] full;
    logic [NUM_EX-1:0] push;
    logic [NUM_EX-1:0] pop;
    logic [NUM_EX-1:0] stall;
    logic [CNTW-1:0]   cnt_w [NUM_EX];

    logic              is_nop;
    logic              sel_full;
    logic              nop_take;
    logic [PERF_W-1:0] perf_nops_q, perf_nops_d;

    assign is_nop = (in_ex_type >= EXW'(NUM_EX));

    // in_ready looks only at flop-based fullness, so out_ready never reaches it.
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < NUM_EX; i++) begin
            if (in_ex_type == EXW'(i)) begin
                sel_full = full[i];
            end
        end
        in_ready = !flush && (is_nop || !sel_full);
    end

    always_comb begin
        push      = '0;
        pop       = '0;
        stall     = '0;
        out_valid = '0;
        occupancy = '0;
        for (int i = 0; i < NUM_EX; i++) begin
            out_valid[i] = (cnt_w[i] != '0) && !flush;
            pop[i]       = out_valid[i] && out_ready[i];
            push[i]      = in_valid && in_ready && !is_nop && (in_ex_type == EXW'(i));
            stall[i]     = in_valid && (in_ex_type == EXW'(i)) && full[i] && !flush;
            occupancy[i*CNTW +: CNTW] = cnt_w[i];
        end
    end

    for (genvar g = 0; g < NUM_EX; g++) begin : g_queue
        vx_gen_dispatch_queue #(
            .DEPTH  (DEPTH),
            .DATAW  (DATAW),
            .PERF_W (PERF_W),
            .CNTW   (CNTW)
        ) u_queue (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (push[g]),
            .push_data (in_data),
            .pop       (pop[g]),
            .stall     (stall[g]),
            .full      (full[g]),
            .count     (cnt_w[g]),
            .head_data (out_data[g*DATAW +: DATAW]),
            .stalls    (perf_stalls[g*PERF_W +: PERF_W])
        );
    end

    // A NOP is consumed whenever it is presented outside a flush.
    assign nop_take = in_valid && is_nop && !flush;

    always_comb begin
        perf_nops_d = perf_nops_q;
        if (nop_take && (perf_nops_q != '1)) begin
            perf_nops_d = perf_nops_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_nops_q <= '0;
        end else begin
            perf_nops_q <= perf_nops_d;
        end
    end

    assign perf_nops = perf_nops_q;

endmodule
